cmos_capture: RTL and testbench
===============================

// Module: cmos_capture
// PURPOSE
//  Receiver for the 8-bit DVP camera bus (cmos_vsyn/cmos_href/cmos_data) driven by the OV-style sensor.
//  Pairs bytes into RGB565 pixels, frames them with start-of-frame/end-of-line marks, and pushes them
//  into the write FIFO that feeds the SDRAM frame buffer. Runs entirely in the pixel-clock domain
//  (CLK = cmos_pclk). Discards the first SKIP_FRAMES frames while the sensor settles.
// PARAMETERS
//  H_PIXELS     640  pixels per line (bytes per line = 2*H_PIXELS)
//  V_LINES      480  lines per frame
//  SKIP_FRAMES  10   complete frames discarded after reset/enable, 0 = none
// PORTS
//  CLK          in   1   pixel clock (cmos_pclk), all logic on rising edge
//  RST          in   1   synchronous reset, active-high
//  enable       in   1   capture enable, level
//  cmos_vsyn    in   1   frame sync, active-high (high = vertical blanking/start of frame)
//  cmos_href    in   1   line valid, active-high
//  cmos_data    in   8   sensor byte, high byte of pixel first
//  fifo_full    in   1   downstream FIFO full
//  pix_data     out  16  {byte0,byte1} RGB565
//  pix_valid    out  1   one-cycle write strobe to FIFO
//  pix_sof      out  1   with pix_valid: first pixel of frame
//  pix_eol      out  1   with pix_valid: last pixel of line
//  frame_done   out  1   one-cycle pulse after last pixel of a complete frame
//  frame_cnt    out  16  captured (non-skipped, complete) frames, wraps at 0xFFFF->0
//  err_line     out  1   sticky: line length != 2*H_PIXELS bytes or line count != V_LINES
//  err_ovf      out  1   sticky: pixel dropped because fifo_full
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, byte phase 0, counters 0. Reset mid-frame discards partial pixel/line.
//  - Input stage: vsyn/href/data registered once; all decisions use registered copies. Vsync rising edge
//    = registered vsyn 1 and its previous value 0.
//  - States: IDLE -> (enable & vsync rise) -> SKIP if skip_cnt<SKIP_FRAMES else ARM.
//    SKIP: each vsync rise increments skip_cnt; at SKIP_FRAMES go ARM. ARM: wait vsyn low -> ACTIVE.
//    ACTIVE: capture; next vsync rise ends frame -> ARM (enable=1) or IDLE (enable=0).
//    skip_cnt cleared only by RST or entering IDLE; enable low mid-frame completes current frame first.
//  - Byte pairing (ACTIVE, href=1): phase 0 latches high byte; phase 1 forms pixel, pix_valid next cycle.
//    Latency: raw low byte at CLK edge n -> pix_valid high during cycle after edge n+1 (2 CLK).
//    Phase resets to 0 whenever href=0.
//  - Line/column: col_cnt counts pixels in line, line_cnt counts lines. pix_eol when col_cnt==H_PIXELS-1.
//    pix_sof when col_cnt==0 and line_cnt==0. href falling edge ends line: line_cnt++ and col_cnt=0.
//  - Odd byte count or col_cnt!=H_PIXELS at href fall: dangling byte dropped, err_line set.
//    Pixels past H_PIXELS in a line: dropped (no pix_valid), err_line set.
//  - Frame end (vsync rise in ACTIVE): if line_cnt==V_LINES and no abort, frame_done pulses 1 cycle,
//    frame_cnt++; else err_line set, no frame_done, frame_cnt unchanged. Lines beyond V_LINES dropped.
//  - vsync rise while href=1: line aborted, frame treated as incomplete (as above).
//  - fifo_full=1 at the cycle pix_valid would assert: pixel suppressed, err_ovf set, counters still advance
//    (geometry kept). frame_done still pulses if geometry correct.
//  - err_line/err_ovf cleared only by RST. frame_done and pix_valid never assert outside ACTIVE/frame-end.
// TESTING  (H_PIXELS=4, V_LINES=2, SKIP_FRAMES=1 unless stated)
//  1. Reset with inputs toggling -> all outputs 0; after release, frame 1 fully ignored (no pix_valid).
//  2. Frame 2 bytes 01..10 -> 8 pix_valid: 0x0102,0x0304,..0x0F10; sof on 0x0102; eol on 0x0708,0x0F10;
//     frame_done 1 cycle after next vsync rise; frame_cnt=1; errors 0; latency exactly 2 CLK.
//  3. Line of 7 bytes -> 3 pixels, byte 7 dropped, err_line=1, no frame_done, frame_cnt unchanged.
//  4. fifo_full high on 3rd pixel -> that pixel absent, err_ovf=1, eol/frame_done timing unchanged.
//  5. vsync rise during href -> line aborted, no frame_done; next clean frame captures normally.
//  6. enable low mid-frame -> frame completes (frame_done), then IDLE, no pixels on following frames;
//     re-enable with SKIP_FRAMES=0 -> capture resumes at next vsync.

Source files
------------

// File: rtl/cmos_capture.sv
// cmos_capture: DVP camera receiver pairing bytes into RGB565 pixels with frame/line marks and settle-frame skip
module cmos_capture #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic        cmos_vsyn,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        fifo_full,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err_line,
  output logic        err_ovf
);
  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int LW = $clog2(V_LINES + 2);
  localparam int SW = $clog2(SKIP_FRAMES + 2);
  localparam logic [CW-1:0] C_H    = CW'(H_PIXELS);
  localparam logic [CW-1:0] C_LAST = CW'(H_PIXELS - 1);
  localparam logic [LW-1:0] C_V    = LW'(V_LINES);
  localparam logic [LW-1:0] C_VMAX = LW'(V_LINES + 1);
  localparam logic [SW-1:0] C_SKIP = SW'(SKIP_FRAMES);

  typedef enum logic [1:0] {IDLE, SKIP, ARM, ACTIVE} state_t;
  state_t r_state, w_next;

  logic          r_vsyn, r_vsyn_d, r_href, r_href_d;
  logic [7:0]    r_data, r_hi;
  logic          r_phase, r_abort, r_pv, r_sof, r_eol;
  logic [CW-1:0] r_col;
  logic [LW-1:0] r_line;
  logic [SW-1:0] r_skip;
  logic          w_vs_rise, w_href_fall, w_active, w_frame_end, w_frame_ok;
  logic          w_pair, w_in_geom, w_overrun, w_line_bad;

  assign w_vs_rise   = r_vsyn & ~r_vsyn_d;
  assign w_href_fall = r_href_d & ~r_href;
  assign w_active    = r_state == ACTIVE;
  assign w_frame_end = w_active & w_vs_rise;
  assign w_frame_ok  = (r_line == C_V) & ~r_abort & ~r_href;
  assign w_pair      = w_active & r_href & r_phase & ~w_vs_rise;
  assign w_in_geom   = (r_col != C_H) & (r_line < C_V);
  assign w_overrun   = w_pair & (r_col == C_H);
  assign w_line_bad  = w_active & w_href_fall & (r_phase | (r_col != C_H));
  assign pix_valid   = r_pv & ~fifo_full;
  assign pix_sof     = pix_valid & r_sof;
  assign pix_eol     = pix_valid & r_eol;

  // Register the sensor bus once; every decision below uses these copies
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vsyn   <= 1'b0;
      r_vsyn_d <= 1'b0;
      r_href   <= 1'b0;
      r_href_d <= 1'b0;
      r_data   <= '0;
    end else begin
      r_vsyn   <= cmos_vsyn;
      r_vsyn_d <= r_vsyn;
      r_href   <= cmos_href;
      r_href_d <= r_href;
      r_data   <= cmos_data;
    end
  end

  // Next state: skip settle frames, wait out vertical blanking, capture until the next frame sync
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (enable & w_vs_rise) ? ((r_skip < C_SKIP) ? SKIP : ARM) : IDLE;
      SKIP:    w_next = (w_vs_rise & (r_skip + 1'b1 >= C_SKIP)) ? ARM : SKIP;
      ARM:     w_next = r_vsyn ? ARM : ACTIVE;
      ACTIVE:  w_next = w_vs_rise ? (enable ? ARM : IDLE) : ACTIVE;
      default: w_next = IDLE;
    endcase
  end

  // State register; the skip count restarts whenever capture falls back to IDLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_next;
      r_skip  <= (w_next == IDLE) ? '0 : (r_state == SKIP && w_vs_rise) ? r_skip + 1'b1 : r_skip;
    end
  end

  // Byte pairing and line/column geometry; counters idle at zero outside ACTIVE
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_phase  <= 1'b0;
      r_hi     <= '0;
      r_col    <= '0;
      r_line   <= '0;
      r_abort  <= 1'b0;
      r_pv     <= 1'b0;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
      pix_data <= '0;
    end else begin
      r_pv  <= w_pair & w_in_geom;
      r_sof <= (r_col == '0) & (r_line == '0);
      r_eol <= r_col == C_LAST;
      if (w_pair) pix_data <= {r_hi, r_data};
      if (!w_active) begin
        r_phase <= 1'b0;
        r_col   <= '0;
        r_line  <= '0;
        r_abort <= 1'b0;
      end else begin
        r_phase <= r_href & ~r_phase;
        if (r_href & ~r_phase) r_hi <= r_data;
        if (w_pair && r_col != C_H) r_col <= r_col + 1'b1;
        if (w_href_fall) begin
          r_col  <= '0;
          r_line <= r_line + LW'(r_line != C_VMAX);
        end
        if (w_overrun | w_line_bad | (w_vs_rise & r_href)) r_abort <= 1'b1;
      end
    end
  end

  // Frame completion pulse, captured-frame counter and sticky error flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_line   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      frame_done <= w_frame_end & w_frame_ok;
      if (w_frame_end & w_frame_ok) frame_cnt <= frame_cnt + 1'b1;
      if ((w_frame_end & ~w_frame_ok) | w_overrun | w_line_bad) err_line <= 1'b1;
      if (r_pv & fifo_full) err_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cmos_capture.sv
// tb_cmos_capture: directed frames against two receivers (one settle frame and none)
module tb_cmos_capture;
  logic        CLK = 1'b0, RST = 1'b1, enable = 1'b1;
  logic        cmos_vsyn = 1'b0, cmos_href = 1'b0, fifo_full = 1'b0;
  logic [7:0]  cmos_data = 8'h00;
  logic [15:0] pix_data, frame_cnt, z_data, z_frame_cnt;
  logic        pix_valid, pix_sof, pix_eol, frame_done, err_line, err_ovf;
  logic        z_valid, z_sof, z_eol, z_done, z_err_line, z_err_ovf;
  int          n_checks = 0, n_fail = 0, cyc = 0, lb_cyc = 0, first_lb = 0, vs_cyc = 0;
  int          z_pix = 0, z_fd = 0;
  logic [15:0] log_d[$];
  logic        log_sof[$], log_eol[$];
  int          log_cyc[$], fd_cyc[$];

  cmos_capture #(.H_PIXELS(4), .V_LINES(2), .SKIP_FRAMES(1)) u_dut (
    .CLK(CLK), .RST(RST), .enable(enable), .cmos_vsyn(cmos_vsyn), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .fifo_full(fifo_full), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_line(err_line), .err_ovf(err_ovf));

  cmos_capture #(.H_PIXELS(4), .V_LINES(2), .SKIP_FRAMES(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .enable(enable), .cmos_vsyn(cmos_vsyn), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .fifo_full(fifo_full), .pix_data(z_data), .pix_valid(z_valid),
    .pix_sof(z_sof), .pix_eol(z_eol), .frame_done(z_done), .frame_cnt(z_frame_cnt),
    .err_line(z_err_line), .err_ovf(z_err_ovf));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (pix_valid === 1'b1) begin
      log_d.push_back(pix_data);
      log_sof.push_back(pix_sof);
      log_eol.push_back(pix_eol);
      log_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) fd_cyc.push_back(cyc);
    if (z_valid === 1'b1) z_pix++;
    if (z_done === 1'b1) z_fd++;
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] d, input logic f);
    cmos_vsyn = v;
    cmos_href = h;
    cmos_data = d;
    fifo_full = f;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_line(input logic [7:0] base, input int nb, input int ff);
    for (int i = 0; i < nb; i++) begin
      if (i == 1) lb_cyc = cyc;
      drive(1'b0, 1'b1, base + 8'(i), i == ff);
    end
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b0, input int n0, input int ff0, input logic [7:0] b1, input int n1);
    send_line(b0, n0, ff0);
    first_lb = lb_cyc;
    send_line(b1, n1, -1);
  endtask

  task automatic vs_pulse();
    vs_cyc = cyc;
    repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      @(negedge CLK);
      n_checks++;
      if ({pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_cnt, err_line, err_ovf} !== 37'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got data=%h v=%b sof=%b eol=%b fd=%b cnt=%h el=%b eo=%b required all 0",
                 pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_cnt, err_line, err_ovf);
      end
    end
    RST = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
    vs_pulse();
    send_frame(8'hA1, 8, -1, 8'hA9, 8);
    vs_pulse();
    n_checks++;
    if (log_d.size() != 0) begin
      n_fail++;
      $display("FAIL skip_frame_pixels: got %0d pixels required 0", log_d.size());
    end
    n_checks++;
    if (fd_cyc.size() != 0 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL skip_frame_done: got %0d pulses cnt=%0d required 0 and 0", fd_cyc.size(), frame_cnt);
    end
  endtask

  task automatic test_capture();
    int lb = log_d.size();
    int fb = fd_cyc.size();
    logic [7:0] b;
    send_frame(8'h01, 8, -1, 8'h09, 8);
    vs_pulse();
    n_checks++;
    if (log_d.size() - lb != 8) begin
      n_fail++;
      $display("FAIL capture_count: got %0d pixels required 8", log_d.size() - lb);
    end else begin
      for (int k = 0; k < 8; k++) begin
        b = 8'(2 * k + 1);
        n_checks++;
        if ({log_d[lb+k], log_sof[lb+k], log_eol[lb+k]} !== {b, b + 8'd1, k == 0, k == 3 || k == 7}) begin
          n_fail++;
          $display("FAIL capture_pixel%0d: got %h sof=%b eol=%b required %h%h sof=%b eol=%b",
                   k, log_d[lb+k], log_sof[lb+k], log_eol[lb+k], b, b + 8'd1, k == 0, k == 3 || k == 7);
        end
      end
      n_checks++;
      if (log_cyc[lb] != first_lb + 2) begin
        n_fail++;
        $display("FAIL capture_latency: got %0d cycles required 2", log_cyc[lb] - first_lb);
      end
    end
    n_checks++;
    if (fd_cyc.size() - fb != 1 || fd_cyc[fb] != vs_cyc + 2) begin
      n_fail++;
      $display("FAIL capture_frame_done: got %0d pulses required 1 at vsync+2", fd_cyc.size() - fb);
    end
    n_checks++;
    if ({frame_cnt, err_line, err_ovf} !== {16'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL capture_status: got cnt=%0d el=%b eo=%b required 1 0 0", frame_cnt, err_line, err_ovf);
    end
  endtask

  task automatic test_short_line();
    int lb = log_d.size();
    int fb = fd_cyc.size();
    send_frame(8'h21, 7, -1, 8'h31, 8);
    vs_pulse();
    n_checks++;
    if (log_d.size() - lb != 7) begin
      n_fail++;
      $display("FAIL short_count: got %0d pixels required 7", log_d.size() - lb);
    end else begin
      n_checks++;
      if ({log_d[lb+2], log_eol[lb+2], log_d[lb+3], log_sof[lb+3], log_eol[lb+6]} !== {16'h2526, 1'b0, 16'h3132, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL short_pixels: got %h eol=%b %h sof=%b eol6=%b required 2526 0 3132 0 1",
                 log_d[lb+2], log_eol[lb+2], log_d[lb+3], log_sof[lb+3], log_eol[lb+6]);
      end
    end
    n_checks++;
    if (fd_cyc.size() != fb || frame_cnt !== 16'd1 || err_line !== 1'b1) begin
      n_fail++;
      $display("FAIL short_status: got fd=%0d cnt=%0d el=%b required 0 1 1", fd_cyc.size() - fb, frame_cnt, err_line);
    end
  endtask

  task automatic test_overflow();
    int lb = log_d.size();
    int fb = fd_cyc.size();
    send_frame(8'h41, 8, 7, 8'h51, 8);
    vs_pulse();
    n_checks++;
    if (log_d.size() - lb != 7) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d pixels required 7", log_d.size() - lb);
    end else begin
      n_checks++;
      if ({log_d[lb+1], log_d[lb+2], log_eol[lb+2], log_d[lb+6], log_eol[lb+6]} !== {16'h4344, 16'h4748, 1'b1, 16'h5758, 1'b1}) begin
        n_fail++;
        $display("FAIL ovf_pixels: got %h %h eol=%b %h eol=%b required 4344 4748 1 5758 1",
                 log_d[lb+1], log_d[lb+2], log_eol[lb+2], log_d[lb+6], log_eol[lb+6]);
      end
    end
    n_checks++;
    if (fd_cyc.size() - fb != 1 || fd_cyc[fb] != vs_cyc + 2) begin
      n_fail++;
      $display("FAIL ovf_frame_done: got %0d pulses required 1 at vsync+2", fd_cyc.size() - fb);
    end
    n_checks++;
    if ({frame_cnt, err_ovf} !== {16'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_status: got cnt=%0d eo=%b required 2 1", frame_cnt, err_ovf);
    end
  endtask

  task automatic test_vsync_abort();
    int lb = log_d.size();
    int fb = fd_cyc.size();
    send_line(8'h61, 8, -1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h69 + 8'(i), 1'b0);
    drive(1'b1, 1'b1, 8'h6D, 1'b0);
    drive(1'b1, 1'b1, 8'h6E, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (log_d.size() - lb != 6 || log_d[log_d.size()-1] !== 16'h6B6C) begin
      n_fail++;
      $display("FAIL abort_pixels: got %0d pixels required 6 ending 6b6c", log_d.size() - lb);
    end
    n_checks++;
    if (fd_cyc.size() != fb || frame_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_status: got fd=%0d cnt=%0d required 0 2", fd_cyc.size() - fb, frame_cnt);
    end
    lb = log_d.size();
    send_frame(8'h71, 8, -1, 8'h79, 8);
    vs_pulse();
    n_checks++;
    if (log_d.size() - lb != 8 || log_d[lb] !== 16'h7172 || log_sof[lb] !== 1'b1) begin
      n_fail++;
      $display("FAIL recover_pixels: got %0d pixels first=%h required 8 first=7172 with sof", log_d.size() - lb, log_d[lb]);
    end
    n_checks++;
    if (fd_cyc.size() - fb != 1 || frame_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL recover_status: got fd=%0d cnt=%0d required 1 3", fd_cyc.size() - fb, frame_cnt);
    end
  endtask

  task automatic test_enable_low();
    int lb = log_d.size();
    int fb = fd_cyc.size();
    int zb = z_pix;
    send_line(8'h81, 8, -1);
    enable = 1'b0;
    send_line(8'h89, 8, -1);
    vs_pulse();
    n_checks++;
    if (log_d.size() - lb != 8 || fd_cyc.size() - fb != 1 || frame_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL enable_low_finish: got px=%0d fd=%0d cnt=%0d required 8 1 4", log_d.size() - lb, fd_cyc.size() - fb, frame_cnt);
    end
    lb = log_d.size();
    fb = fd_cyc.size();
    zb = z_pix;
    send_frame(8'h91, 8, -1, 8'h99, 8);
    vs_pulse();
    n_checks++;
    if (log_d.size() != lb || fd_cyc.size() != fb || z_pix != zb || frame_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL enable_low_idle: got px=%0d fd=%0d zpx=%0d cnt=%0d required 0 0 0 4",
               log_d.size() - lb, fd_cyc.size() - fb, z_pix - zb, frame_cnt);
    end
  endtask

  task automatic test_reenable();
    int lb, fb, zb, zf;
    enable = 1'b1;
    vs_pulse();
    lb = log_d.size();
    fb = fd_cyc.size();
    zb = z_pix;
    zf = z_fd;
    send_frame(8'hC1, 8, -1, 8'hC9, 8);
    vs_pulse();
    n_checks++;
    if (z_pix - zb != 8 || z_fd - zf != 1 || z_frame_cnt !== 16'd6) begin
      n_fail++;
      $display("FAIL reenable_noskip: got px=%0d fd=%0d cnt=%0d required 8 1 6", z_pix - zb, z_fd - zf, z_frame_cnt);
    end
    n_checks++;
    if (log_d.size() != lb || fd_cyc.size() != fb) begin
      n_fail++;
      $display("FAIL reenable_skip: got px=%0d fd=%0d required 0 0", log_d.size() - lb, fd_cyc.size() - fb);
    end
    lb = log_d.size();
    send_frame(8'hD1, 8, -1, 8'hD9, 8);
    vs_pulse();
    n_checks++;
    if (log_d.size() - lb != 8 || log_d[lb] !== 16'hD1D2 || fd_cyc.size() - fb != 1 || frame_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL reenable_capture: got px=%0d first=%h fd=%0d cnt=%0d required 8 d1d2 1 5",
               log_d.size() - lb, log_d[lb], fd_cyc.size() - fb, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_short_line();
    test_overflow();
    test_vsync_abort();
    test_enable_low();
    test_reenable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
